// File: rtl/kb_scancode_fifo.sv
// kb_scancode_fifo: PS/2 set-2 scancode decoder feeding a first-word fall-through ASCII FIFO.
// Define KB_EXTENDED_KEYS_EN to push arrow-key codes 0x11..0x14 for E0-prefixed makes.
module kb_scancode_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [7:0]                    Byte_In,
  input  logic                          Byte_Valid,
  input  logic                          Key_Rd,
  input  logic                          Ovf_Clr,
  output logic [7:0]                    Key_Data,
  output logic                          Key_Valid,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
  output logic                          Shift_State,
  output logic                          Overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  // {hit, lower-case ascii}; shift is applied afterwards so letters share one table
  function automatic logic [8:0] make_map(input logic [7:0] b);
    case (b)
      8'h1C: return 9'h161; 8'h32: return 9'h162; 8'h21: return 9'h163; 8'h23: return 9'h164;
      8'h24: return 9'h165; 8'h2B: return 9'h166; 8'h34: return 9'h167; 8'h33: return 9'h168;
      8'h43: return 9'h169; 8'h3B: return 9'h16A; 8'h42: return 9'h16B; 8'h4B: return 9'h16C;
      8'h3A: return 9'h16D; 8'h31: return 9'h16E; 8'h44: return 9'h16F; 8'h4D: return 9'h170;
      8'h15: return 9'h171; 8'h2D: return 9'h172; 8'h1B: return 9'h173; 8'h2C: return 9'h174;
      8'h3C: return 9'h175; 8'h2A: return 9'h176; 8'h1D: return 9'h177; 8'h22: return 9'h178;
      8'h35: return 9'h179; 8'h1A: return 9'h17A;
      8'h45: return 9'h130; 8'h16: return 9'h131; 8'h1E: return 9'h132; 8'h26: return 9'h133;
      8'h25: return 9'h134; 8'h2E: return 9'h135; 8'h36: return 9'h136; 8'h3D: return 9'h137;
      8'h3E: return 9'h138; 8'h46: return 9'h139;
      8'h29: return 9'h120; 8'h5A: return 9'h10D; 8'h66: return 9'h108; 8'h76: return 9'h11B;
      default: return 9'h000;
    endcase
  endfunction

  logic [7:0]   byte_q;
  logic         bv_q;
  state_t       state_q;
  logic         shift_q;
  logic         dec_v_q;
  logic [7:0]   dec_d_q;
  logic [7:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]  count_q, count_d;
  logic         ovf_q;
  logic [8:0]   mk, ext;
  logic         is_shift, full, pop, wr_en;

  assign mk       = make_map(byte_q);
  assign is_shift = byte_q == 8'h12 || byte_q == 8'h59;
`ifdef KB_EXTENDED_KEYS_EN
  assign ext = byte_q == 8'h75 ? 9'h111 : byte_q == 8'h72 ? 9'h112 :
               byte_q == 8'h6B ? 9'h113 : byte_q == 8'h74 ? 9'h114 : 9'h000;
`else
  assign ext = 9'h000;
`endif

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      byte_q <= '0;
      bv_q   <= 1'b0;
    end else begin
      byte_q <= Byte_In;
      bv_q   <= Byte_Valid;
    end

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state_q <= IDLE;
      shift_q <= 1'b0;
      dec_v_q <= 1'b0;
      dec_d_q <= '0;
    end else begin
      dec_v_q <= 1'b0;
      if (bv_q)
        case (state_q)
          IDLE: begin
            if (byte_q == 8'hF0) state_q <= BRK;
            else if (byte_q == 8'hE0) state_q <= EXT;
            else if (is_shift) shift_q <= 1'b1;
            else if (mk[8]) begin
              dec_v_q <= 1'b1;
              dec_d_q <= (shift_q && mk[7:0] >= 8'h61 && mk[7:0] <= 8'h7A) ? mk[7:0] - 8'h20 : mk[7:0];
            end
          end
          BRK: begin
            state_q <= IDLE;
            if (is_shift) shift_q <= 1'b0;
          end
          EXT: begin
            if (byte_q == 8'hF0) state_q <= EXT_BRK;
            else begin
              state_q <= IDLE;
              dec_v_q <= ext[8];
              dec_d_q <= ext[8] ? ext[7:0] : dec_d_q;
            end
          end
          default: state_q <= IDLE;
        endcase
    end

  // a full FIFO still accepts a push when the head is popped in the same cycle
  assign full    = count_q == (AW+1)'(FIFO_DEPTH);
  assign pop     = Key_Rd && count_q != '0;
  assign wr_en   = dec_v_q && (!full || pop);
  assign count_d = (wr_en && !pop) ? count_q + 1'b1 : (pop && !wr_en) ? count_q - 1'b1 : count_q;

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_en ? wr_q + 1'b1 : wr_q;
      rd_q    <= pop ? rd_q + 1'b1 : rd_q;
      count_q <= count_d;
      ovf_q   <= (dec_v_q && full && !pop) || (ovf_q && !Ovf_Clr);
    end

  always_ff @(posedge Clk)
    if (wr_en) mem[wr_q] <= dec_d_q;

  assign Key_Valid   = count_q != '0;
  assign Key_Data    = Key_Valid ? mem[rd_q] : 8'h00;
  assign Fifo_Count  = count_q;
  assign Shift_State = shift_q;
  assign Overflow    = ovf_q;
endmodule

// File: tb/tb_kb_scancode_fifo.sv
// tb_kb_scancode_fifo: directed decode table plus FIFO corner sequences for kb_scancode_fifo.
module tb_kb_scancode_fifo;
  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [7:0] Byte_In = '0;
  logic       Byte_Valid = 1'b0;
  logic       Key_Rd = 1'b0;
  logic       Ovf_Clr = 1'b0;
  logic [7:0] Key_Data;
  logic       Key_Valid;
  logic [3:0] Fifo_Count;
  logic       Shift_State;
  logic       Overflow;
  int total = 0;
  int bad = 0;

  kb_scancode_fifo #(.FIFO_DEPTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Byte_In(Byte_In), .Byte_Valid(Byte_Valid),
    .Key_Rd(Key_Rd), .Ovf_Clr(Ovf_Clr), .Key_Data(Key_Data), .Key_Valid(Key_Valid),
    .Fifo_Count(Fifo_Count), .Shift_State(Shift_State), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] code;
    logic       sh;
    logic       push;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [16];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge Clk); #1 Byte_In = b; Byte_Valid = 1'b1;
    @(posedge Clk); #1 Byte_Valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic pop();
    @(posedge Clk); #1 Key_Rd = 1'b1;
    @(posedge Clk); #1 Key_Rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge Clk); #1 Ovf_Clr = 1'b1;
    @(posedge Clk); #1 Ovf_Clr = 1'b0;
  endtask

  initial begin
    vt[0]  = '{8'h1C, 1'b0, 1'b1, 8'h61};
    vt[1]  = '{8'h32, 1'b0, 1'b1, 8'h62};
    vt[2]  = '{8'h1A, 1'b0, 1'b1, 8'h7A};
    vt[3]  = '{8'h4D, 1'b1, 1'b1, 8'h50};
    vt[4]  = '{8'h15, 1'b1, 1'b1, 8'h51};
    vt[5]  = '{8'h45, 1'b1, 1'b1, 8'h30};
    vt[6]  = '{8'h16, 1'b0, 1'b1, 8'h31};
    vt[7]  = '{8'h46, 1'b0, 1'b1, 8'h39};
    vt[8]  = '{8'h29, 1'b1, 1'b1, 8'h20};
    vt[9]  = '{8'h5A, 1'b0, 1'b1, 8'h0D};
    vt[10] = '{8'h66, 1'b0, 1'b1, 8'h08};
    vt[11] = '{8'h76, 1'b0, 1'b1, 8'h1B};
    vt[12] = '{8'hAA, 1'b0, 1'b0, 8'h00};
    vt[13] = '{8'hFA, 1'b0, 1'b0, 8'h00};
    vt[14] = '{8'h0E, 1'b0, 1'b0, 8'h00};
    vt[15] = '{8'hFF, 1'b1, 1'b0, 8'h00};

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_count", Fifo_Count, 0);
    chk("rst_valid", Key_Valid, 0);
    chk("rst_data", Key_Data, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_shift", Shift_State, 0);
    Rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vt[i].sh) send(8'h12);
      send(vt[i].code);
      settle();
      chk($sformatf("vec%0d_count", i), Fifo_Count, vt[i].push ? 1 : 0);
      if (vt[i].push) begin
        chk($sformatf("vec%0d_data", i), Key_Data, vt[i].exp);
        pop();
      end
      if (vt[i].sh) begin
        send(8'hF0); send(8'h12);
      end
      settle();
      chk($sformatf("vec%0d_shift_rel", i), Shift_State, 0);
    end

    pop();
    chk("empty_pop_count", Fifo_Count, 0);

    // latency: strobe at edge N, entry visible only after N+2
    send(8'h1C);
    chk("lat_n", Key_Valid, 0);
    @(posedge Clk); #1;
    chk("lat_n1", Key_Valid, 0);
    @(posedge Clk); #1;
    chk("lat_n2", Key_Valid, 1);
    send(8'hF0); send(8'h1C);
    settle();
    chk("brk_nopush", Fifo_Count, 1);
    chk("brk_data", Key_Data, 8'h61);
    pop();

    send(8'h12);
    settle();
    chk("shift_set", Shift_State, 1);
    send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    settle();
    chk("shift_clr", Shift_State, 0);
    chk("shift_count", Fifo_Count, 2);
    chk("shift_upper", Key_Data, 8'h41);
    pop();
    chk("shift_lower", Key_Data, 8'h61);
    pop();

    repeat (9) send(8'h29);
    settle();
    chk("ovf_count", Fifo_Count, 8);
    chk("ovf_set", Overflow, 1);
    pulse_clr();
    chk("ovf_clr", Overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), Key_Data, 8'h20);
      pop();
    end
    chk("drain_empty", Key_Valid, 0);

    // push 0x5A into a full FIFO while the head is popped in the same edge
    repeat (8) send(8'h29);
    settle();
    send(8'h5A);
    @(posedge Clk); #1 Key_Rd = 1'b1;
    @(posedge Clk); #1 Key_Rd = 1'b0;
    chk("fullrw_count", Fifo_Count, 8);
    chk("fullrw_ovf", Overflow, 0);
    repeat (7) pop();
    chk("fullrw_tail_count", Fifo_Count, 1);
    chk("fullrw_tail", Key_Data, 8'h0D);
    pop();

    repeat (8) send(8'h29);
    settle();
    send(8'h29);
    @(posedge Clk); #1 Ovf_Clr = 1'b1;
    @(posedge Clk); #1 Ovf_Clr = 1'b0;
    chk("ovf_clr_coincide", Overflow, 1);
    pulse_clr();
    chk("ovf_clr2", Overflow, 0);
    repeat (8) pop();
    chk("drain2_count", Fifo_Count, 0);

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    settle();
`ifdef KB_EXTENDED_KEYS_EN
    chk("ext_count", Fifo_Count, 1);
    chk("ext_data", Key_Data, 8'h11);
    pop();
`else
    chk("ext_count", Fifo_Count, 0);
`endif
    send(8'hE0); send(8'h1C);
    settle();
    chk("ext_unmapped", Fifo_Count, 0);

    repeat (3) send(8'h1C);
    settle();
    chk("pre_rst_count", Fifo_Count, 3);
    send(8'hF0);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_rst_count", Fifo_Count, 0);
    chk("async_rst_data", Key_Data, 0);
    @(posedge Clk); #1 Rst_n = 1'b1;
    send(8'h1C);
    settle();
    chk("post_rst_count", Fifo_Count, 1);
    chk("post_rst_data", Key_Data, 8'h61);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
